// File: rtl/uart_pkg.sv
// Shared UART types: transmitter states, parity modes and the data-bits encoding.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam logic [1:0] BITS_5 = 2'b00;
   localparam logic [1:0] BITS_6 = 2'b01;
   localparam logic [1:0] BITS_7 = 2'b10;
   localparam logic [1:0] BITS_8 = 2'b11;

   // Number of data bits (5..8) selected by a cfg_bits code.
   function automatic logic [3:0] bit_count(input logic [1:0] bits);
      return 4'(bits) + 4'd5;
   endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte write handshake into the buffered UART transmitter.
interface uart_tx_buffered_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, registered occupancy count; read data is the head entry (no fall-through).
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage is not reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter with runtime frame format; parity support built only
// when UART_TX_PARITY_EN is defined.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned BAUD_W     = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [BAUD_W-1:0]           baud_div,
   input  logic [1:0]                  cfg_bits,
   input  logic                        cfg_stop2,
   input  logic [1:0]                  cfg_parity,
   uart_tx_buffered_if.slave           s,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        busy,
   output logic                        tx_done,
   output logic                        tx_o
);
   state_e            state, state_n;
   logic [BAUD_W-1:0] cnt, cnt_n, div_q, div_n;
   logic [7:0]        sh, sh_n;
   logic [2:0]        idx, idx_n, last_q, last_n;
   logic              stop2_q, stop2_n, stop_idx, stop_idx_n;
   logic              tx_n, done_n, load, full, empty;
   logic [7:0]        fifo_rd;
   logic              bit_end;

`ifdef UART_TX_PARITY_EN
   logic par_en_q, par_en_n, odd_q, odd_n, acc, acc_n;
`else
   logic unused_parity;
   assign unused_parity = ^cfg_parity;
`endif

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (s.s_valid),
      .pop     (load),
      .wr_data (s.s_data),
      .rd_data (fifo_rd),
      .count   (fifo_count),
      .full    (full),
      .empty   (empty)
   );

   assign s.s_ready = !full;
   assign bit_end   = (cnt == div_q - BAUD_W'(1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         div_q    <= BAUD_W'(2);
         sh       <= '0;
         idx      <= '0;
         last_q   <= '0;
         stop2_q  <= 1'b0;
         stop_idx <= 1'b0;
         tx_o     <= 1'b1;
         tx_done  <= 1'b0;
         busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q <= 1'b0;
         odd_q    <= 1'b0;
         acc      <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         div_q    <= div_n;
         sh       <= sh_n;
         idx      <= idx_n;
         last_q   <= last_n;
         stop2_q  <= stop2_n;
         stop_idx <= stop_idx_n;
         tx_o     <= tx_n;
         tx_done  <= done_n;
         busy     <= (state_n != IDLE);
`ifdef UART_TX_PARITY_EN
         par_en_q <= par_en_n;
         odd_q    <= odd_n;
         acc      <= acc_n;
`endif
      end
   end

   // tx_n is the line level for the coming cycle, so tx_o never lags the state.
   always_comb begin
      state_n    = state;
      cnt_n      = bit_end ? '0 : cnt + BAUD_W'(1);
      div_n      = div_q;
      sh_n       = sh;
      idx_n      = idx;
      last_n     = last_q;
      stop2_n    = stop2_q;
      stop_idx_n = stop_idx;
      tx_n       = 1'b1;
      done_n     = 1'b0;
      load       = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_n   = par_en_q;
      odd_n      = odd_q;
      acc_n      = acc;
`endif
      case (state)
         IDLE: begin
            cnt_n = '0;
            load  = !empty;
         end
         START: begin
            tx_n = 1'b0;
            if (bit_end) begin
               state_n = DATA;
               tx_n    = sh[0];
            end
         end
         DATA: begin
            tx_n = sh[0];
            if (bit_end) begin
               sh_n  = {1'b0, sh[7:1]};
               idx_n = idx + 3'd1;
               tx_n  = sh[1];
               if (idx == last_q) begin
                  state_n    = STOP;
                  stop_idx_n = 1'b0;
                  tx_n       = 1'b1;
`ifdef UART_TX_PARITY_EN
                  acc_n = acc ^ sh[0];
                  if (par_en_q) begin
                     state_n = PARITY;
                     tx_n    = acc ^ sh[0] ^ odd_q;
                  end
`endif
               end
`ifdef UART_TX_PARITY_EN
               else begin
                  acc_n = acc ^ sh[0];
               end
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            tx_n = acc ^ odd_q;
            if (bit_end) begin
               state_n    = STOP;
               stop_idx_n = 1'b0;
               tx_n       = 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (stop2_q && !stop_idx) begin
                  stop_idx_n = 1'b1;
               end else begin
                  done_n  = 1'b1;
                  state_n = IDLE;
                  load    = !empty;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // Pop and latch the whole frame format so mid-frame config changes are ignored.
      if (load) begin
         state_n = START;
         tx_n    = 1'b0;
         cnt_n   = '0;
         div_n   = (baud_div < BAUD_W'(2)) ? BAUD_W'(2) : baud_div;
         sh_n    = fifo_rd;
         idx_n   = '0;
         last_n  = 3'(bit_count(cfg_bits) - 4'd1);
         stop2_n = cfg_stop2;
`ifdef UART_TX_PARITY_EN
         par_en_n = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
         odd_n    = (cfg_parity == PAR_ODD);
         acc_n    = 1'b0;
`endif
      end
   end

endmodule
